// File: rtl/coef_block_axis_tx.sv
// Zig-zag to raster reorder for 8x8 coefficient blocks, streamed out as eight
// AXI-Stream row beats per block through a two-bank ping-pong buffer.
module coef_block_axis_tx #(
  parameter int COEF_WIDTH             = 8,
  parameter int C_M00_AXIS_TDATA_WIDTH = 64
) (
  input  logic                                  clk_in,
  input  logic                                  rst_in,
  input  logic                                  valid_in,
  input  logic [COEF_WIDTH-1:0]                 coef_in,
  output logic                                  ready_out,
  input  logic                                  m00_axis_tready,
  output logic                                  m00_axis_tvalid,
  output logic                                  m00_axis_tlast,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
  output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tstrb
);

  // Raster address for each zig-zag index.
  localparam logic [5:0] ZZ [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND} state_t;

  state_t                              state_q, state_d;
  logic [1:0]                          full_q, full_d;
  logic                                wr_bank_q, wr_bank_d;
  logic                                rd_bank_q, rd_bank_d;
  logic [5:0]                          k_q, k_d;
  logic [2:0]                          r_q, r_d;
  logic                                tvalid_q, tvalid_d;
  logic [C_M00_AXIS_TDATA_WIDTH-1:0]   tdata_q, tdata_d;

  // Address is {bank, row, col}; bank A occupies the lower half.
  logic signed [COEF_WIDTH-1:0]        mem_q [128];

  logic                                accept;
  logic                                load_row;
  logic                                row_bank;
  logic [2:0]                          row_idx;
  logic [C_M00_AXIS_TDATA_WIDTH-1:0]   row_data;

  assign ready_out       = !full_q[wr_bank_q];
  assign accept          = valid_in && ready_out;
  assign m00_axis_tvalid = tvalid_q;
  assign m00_axis_tlast  = tvalid_q && (r_q == 3'd7);
  assign m00_axis_tdata  = tdata_q;
  assign m00_axis_tstrb  = '1;

  always_ff @(posedge clk_in) begin
    if (accept) begin
      mem_q[{wr_bank_q, ZZ[k_q]}] <= coef_in;
    end
  end

  always_comb begin
    row_data = '0;
    for (int c = 0; c < 8; c++) begin
      row_data[c*COEF_WIDTH +: COEF_WIDTH] = mem_q[{row_bank, row_idx, 3'(c)}];
    end
  end

  always_comb begin
    state_d   = state_q;
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    k_d       = k_q;
    r_d       = r_q;
    tvalid_d  = tvalid_q;
    tdata_d   = tdata_q;
    load_row  = 1'b0;
    row_bank  = rd_bank_q;
    row_idx   = 3'd0;

    if (accept) begin
      k_d = k_q + 6'd1;
      if (k_q == 6'd63) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (full_q[rd_bank_q]) state_d = S_LOAD;
      end
      S_LOAD: begin
        load_row = 1'b1;
        r_d      = 3'd0;
        tvalid_d = 1'b1;
        state_d  = S_SEND;
      end
      S_SEND: begin
        if (tvalid_q && m00_axis_tready) begin
          if (r_q != 3'd7) begin
            load_row = 1'b1;
            row_idx  = r_q + 3'd1;
            r_d      = r_q + 3'd1;
          end else begin
            // Release never collides with a fill: the fill targets the other bank.
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
            r_d               = 3'd0;
            if (full_q[~rd_bank_q]) begin
              load_row = 1'b1;
              row_bank = ~rd_bank_q;
            end else begin
              tvalid_d = 1'b0;
              state_d  = S_IDLE;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (load_row) tdata_d = row_data;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= S_IDLE;
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      k_q       <= '0;
      r_q       <= '0;
      tvalid_q  <= 1'b0;
      tdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      k_q       <= k_d;
      r_q       <= r_d;
      tvalid_q  <= tvalid_d;
      tdata_q   <= tdata_d;
    end
  end

endmodule

// File: doc/coef_block_axis_tx.md
# coef_block_axis_tx

AXI-Stream transmitter that feeds 8x8 coefficient blocks to the 2-D IDCT DMA input. It accepts 64 signed coefficients per block in JPEG zig-zag order, reorders them to raster order in a ping-pong buffer, and emits each block as eight 64-bit row beats with `tlast` on row 7. It sits between the entropy/dequant stage and the IDCT's S00_AXIS slave port. Buffering lets one block be loaded while the previous one streams.

## Interface

Parameters:
- `COEF_WIDTH`, 8: bits per signed coefficient.
- `C_M00_AXIS_TDATA_WIDTH`, 64: row beat width; must equal 8*COEF_WIDTH.

Ports:
- `clk_in`  in  1  single clock for all logic.
- `rst_in`  in  1  asynchronous, active-high reset.
- `valid_in`  in  1  coefficient strobe.
- `coef_in`  in  COEF_WIDTH  coefficient, zig-zag order, index 0 first.
- `ready_out`  out  1  high when a coefficient can be accepted.
- `m00_axis_tready`  in  1  downstream ready.
- `m00_axis_tvalid`  out  1  row beat valid.
- `m00_axis_tlast`  out  1  high on row 7 of each block.
- `m00_axis_tdata`  out  C_M00_AXIS_TDATA_WIDTH  row data; column c at bits [8c+7:8c].
- `m00_axis_tstrb`  out  C_M00_AXIS_TDATA_WIDTH/8  constant all-ones.

## Operation

- Two banks (A, B), each 64 x COEF_WIDTH, each with a `full` flag. The write pointer starts at A and the read pointer starts at A.
- Input accept happens when `valid_in && ready_out`. `ready_out` = !full[write bank].
- Each accepted coefficient is written to raster address ZZ[k], where k is a 6-bit zig-zag counter. ZZ is the standard JPEG table: 0,1,8,16,9,2,3,10,17,24,...,62,63.
- When the accept has k=63: set full[write bank], toggle the write bank, and reset k to 0.
- Output FSM:
  - IDLE: go to LOAD when full[read bank].
  - LOAD: register row r=0 into the tdata register, assert tvalid, go to SEND.
  - SEND: on handshake (`tvalid && tready`):
    - If r<7: load row r+1 and keep tvalid high.
    - If r==7: clear full[read bank] and toggle the read bank. If the other bank is full, load its row 0 on the same edge and stay in SEND. Otherwise drop tvalid and go to IDLE.
- `tlast` = (r==7) while tvalid.
- If a bank is filling while it is being released, both happen on the same edge: the release clears full and the fill sets it on the other bank. There is no conflict because the fill and release always target different banks.
- No data transformation: coefficients are passed bit-exact.

## Timing

- Reset values: `ready_out`=1 (combinational from cleared flags), `m00_axis_tvalid`=0, `m00_axis_tlast`=0, `m00_axis_tdata`=0, `m00_axis_tstrb`=all-ones. FSM=IDLE, k=0, r=0, both full flags=0, both bank pointers=A.
- Latency: the 64th coefficient is accepted at edge t, full is set at t, the FSM enters LOAD at edge t+1, and tvalid=1 with row 0 is visible after edge t+2.
- Throughput with tready held high: 8 consecutive beats per block. Blocks stream back-to-back with no gap when the next bank is already full.
- AXIS rules: once tvalid is asserted, tdata/tlast stay stable until handshake. tvalid never depends combinationally on tready.
- Backpressure: when both banks are full, `ready_out`=0 and input stalls. `ready_out` returns to 1 the cycle after the row-7 handshake of the streaming bank.
- Reset mid-operation, asynchronous: partial input is discarded, any in-flight block is dropped, and tvalid falls immediately.

## Test plan

- Single block, coef_in=k for k=0..63, tready=1. Expected: tvalid 2 cycles after the last accept, then 8 beats:
  - row0 = 64'h1C1B0F0E06050100
  - row1 = 64'h2A1D1A100D070402
  - row7 = 64'h3F3E3A3931302423 with tlast=1
  - tvalid=0 afterwards.
- Backpressure: same block, tready toggled 1,0,0,1,... Expected: each beat holds stable while tready=0, 8 beats total, no duplicates.
- Ping-pong: three blocks (values k, k+64, k-128 as 8-bit signed), pushed continuously with tready=0 until ready_out falls. Expected: ready_out=0 after the 128th accept. Releasing tready gives 24 beats with no gap between blocks 1 and 2, and ready_out rises after block 1 row 7.
- Negative values: all coef_in=8'h80. Expected: every row = 64'h8080808080808080 and tstrb=8'hFF.
- Reset mid-block: assert rst_in after 30 coefficients. Expected: no output. Then a full block with coef_in=k yields exactly the first-scenario rows.
- Reset during streaming: assert rst_in after row 3 handshake. Expected: tvalid=0 immediately, ready_out=1, no residual beats.
